seq_divider: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 106 ++++++++++
 tb/tb_seq_divider.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, FSM encoding and constants for the lab datapath's sequential divider.
package alu_pkg;
  localparam int N_DIVIDEND = 4;
  localparam int N_DIVISOR  = 2;
  localparam int STEP_W     = 2;

  localparam logic [STEP_W-1:0]     LAST_STEP    = 2'd3;
  localparam logic [N_DIVIDEND-1:0] DBZ_QUOTIENT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module div_step
  import alu_pkg::*;
(
  input  logic [N_DIVISOR:0]   r_in,
  input  logic                 dvd_bit,
  input  logic [N_DIVISOR-1:0] divisor,
  output logic [N_DIVISOR:0]   r_out,
  output logic                 q_bit
);
  logic [N_DIVISOR:0] r_shift;

  assign r_shift = {r_in[N_DIVISOR-1:0], dvd_bit};

  // r_in[MSB] is always 0 when fed back from a previous step; counting it still
  // keeps the step correct for any input, since a set MSB means the shifted
  // value exceeds every possible divisor.
  assign q_bit = r_in[N_DIVISOR] || (r_shift >= {1'b0, divisor});
  assign r_out = q_bit ? (r_shift - {1'b0, divisor}) : r_shift;
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (4-bit dividend / 2-bit divisor), one quotient
// bit per clock, with a start/busy/done handshake.
module seq_divider
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_DIVIDEND-1:0] dividend,
  input  logic [N_DIVISOR-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [N_DIVIDEND-1:0] quotient,
  output logic [N_DIVISOR-1:0]  remainder,
  output logic                  dbz
);
  // Handshake: start is accepted only on a clock edge where the FSM is IDLE;
  // start in RUN or DONE is dropped, never queued. busy is high exactly while
  // iterating, done is a one-cycle pulse, and the result outputs are stable
  // from the done cycle until the next result is loaded.

  state_t state, state_nxt;

  logic [N_DIVIDEND-1:0] dvd_q;
  logic [N_DIVISOR-1:0]  dvs_q;
  logic [N_DIVISOR:0]    r_q;
  logic [N_DIVIDEND-2:0] q_acc;
  logic [STEP_W-1:0]     step_q;

  logic [N_DIVISOR:0] r_next;
  logic               q_bit;

  div_step u_step (
    .r_in    (r_q),
    .dvd_bit (dvd_q[N_DIVIDEND-1]),
    .divisor (dvs_q),
    .r_out   (r_next),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (divisor == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (step_q == LAST_STEP) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      r_q       <= '0;
      q_acc     <= '0;
      step_q    <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              dvd_q  <= dividend;
              dvs_q  <= divisor;
              r_q    <= '0;
              q_acc  <= '0;
              step_q <= '0;
            end else begin
              quotient  <= DBZ_QUOTIENT;
              remainder <= '0;
              dbz       <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Dividend shifts left so its MSB is always the next bit to consume.
          dvd_q  <= {dvd_q[N_DIVIDEND-2:0], 1'b0};
          r_q    <= r_next;
          q_acc  <= {q_acc[N_DIVIDEND-3:0], q_bit};
          step_q <= step_q + STEP_W'(1);
          if (step_q == LAST_STEP) begin
            quotient  <= {q_acc, q_bit};
            remainder <= r_next[N_DIVISOR-1:0];
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed checks of seq_divider against an arithmetic model,
// with a scoreboard queue consumed by an independent done monitor.
module tb_seq_divider;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [1:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [1:0] remainder;
  logic       dbz;

  int checks   = 0;
  int failures = 0;

  // Expected result packed as {quotient, remainder, dbz}.
  logic [6:0] exp_q[$];

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model(input int a, input int b);
    if (b == 0) return {4'hF, 2'd0, 1'b1};
    return {4'(a / b), 2'(a % b), 1'b0};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [6:0] e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("quotient",  int'(quotient),  int'(e[6:3]));
        check("remainder", int'(remainder), int'(e[2:1]));
        check("dbz",       int'(dbz),       int'(e[0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one division from IDLE, optionally pokes start mid-RUN, then times
  // done and busy against the expected schedule.
  task automatic run_div(input int a, input int b, input logic [6:0] exp, input bit poke);
    int edges;
    int busy_cycles;
    start    = 1'b1;
    dividend = 4'(a);
    divisor  = 2'(b);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 2'($urandom);
    edges       = 0;
    busy_cycles = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      if (poke && edges == 1) begin
        start    = 1'b1;
        dividend = 4'($urandom);
        divisor  = 2'($urandom_range(1, 3));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check("done_latency", edges, (b == 0) ? 0 : 4);
    check("busy_cycles", busy_cycles, (b == 0) ? 0 : 4);
    @(posedge clk); #1;
    check("done_pulse_width", int'(done), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_done"},      int'(done),      0);
    check({tag, "_quotient"},  int'(quotient),  0);
    check({tag, "_remainder"}, int'(remainder), 0);
    check({tag, "_dbz"},       int'(dbz),       0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-computed results.
    run_div(9, 2,  {4'd4,  2'd1, 1'b0}, 1'b0);
    run_div(15, 1, {4'd15, 2'd0, 1'b0}, 1'b0);
    run_div(2, 3,  {4'd0,  2'd2, 1'b0}, 1'b0);
    run_div(0, 3,  {4'd0,  2'd0, 1'b0}, 1'b0);
    run_div(7, 0,  {4'hF,  2'd0, 1'b1}, 1'b0);
    run_div(6, 3,  {4'd2,  2'd0, 1'b0}, 1'b0);
    run_div(12, 3, {4'd4,  2'd0, 1'b0}, 1'b1);

    // Reset two cycles into RUN of 13/2: operation dropped, no done.
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("midrun_reset");
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_idle_busy", int'(busy), 0);
    run_div(13, 2, {4'd6, 2'd1, 1'b0}, 1'b0);

    // Exhaustive nonzero-divisor sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 4; b++)
        run_div(a, b, model(a, b), 1'b0);

    // Round trip of every 2-bit multiply with B != 0.
    for (int a = 0; a < 4; a++)
      for (int b = 1; b < 4; b++)
        run_div(a * b, b, {4'(a), 2'd0, 1'b0}, 1'b0);

    // Random mix, including divide-by-zero and mid-RUN pokes.
    repeat (40) begin
      int a;
      int b;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 3));
      run_div(a, b, model(a, b), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
